// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg
//   Shared types and constants for the sequential binary-to-BCD converter.
//   - state_t         : converter FSM states (IDLE, SHIFT, DONE)
//   - BCD_ADJ_THRESH  : digit value at or above which the add-3 fires
//   - BCD_ADJ_ADD     : the add-3 correction amount
//   - bcd_digits()    : minimum number of decimal digits for a given binary width
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  // Smallest digit count d with 10**d > 2**width - 1 (valid for width up to 63).
  function automatic int bcd_digits(input int width);
    longint unsigned max_v;
    longint unsigned pow_v;
    int              digits;
    max_v  = (64'd1 << width) - 64'd1;
    pow_v  = 64'd10;
    digits = 1;
    for (int k = 0; k < 20; k++) begin
      if (pow_v <= max_v) begin
        pow_v = pow_v * 64'd10;
        digits++;
      end
    end
    return digits;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// bcd_digit_adjust
//   Combinational double-dabble digit correction: adds 3 to a BCD digit that
//   is 5 or more so the following left shift carries correctly into the next
//   decimal digit. Inputs 0..9 map to 0..12, so the result never overflows.
//   Ports:
//     i_digit [3:0] : accumulator digit before the shift
//     o_digit [3:0] : corrected digit
module bcd_digit_adjust
  import bin2bcd_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  // Add-3 correction when the digit would reach 10 or more after doubling.
  always_comb begin
    o_digit = i_digit;
    if (i_digit >= BCD_ADJ_THRESH) begin
      o_digit = i_digit + BCD_ADJ_ADD;
    end else begin
      o_digit = i_digit;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
//   Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
//   feeding a seven-segment decode stage. A conversion takes WIDTH+1 cycles
//   from the accepting edge to the oDONE pulse; starts are ignored while busy.
//   Optional feature macro: BIN2BCD_LZ_BLANK_EN enables the leading-zero
//   blank mask on oBLANK; without it oBLANK is constant zero.
//   Parameters:
//     WIDTH  : binary input width
//     DIGITS : number of BCD digits (must cover 2**WIDTH-1)
//   Ports:
//     iCLK   : clock, rising edge
//     iRST   : asynchronous active-high reset
//     iSTART : conversion request, sampled only in IDLE
//     iBIN   : binary operand, captured on the accepting edge
//     oBUSY  : conversion in flight (through the cycle oDONE is high)
//     oDONE  : one-cycle pulse when oBCD updates
//     oBCD   : packed digits, digit i at [4i+3:4i], held until next oDONE
//     oBLANK : leading-zero blank mask (digit 0 never blanked)
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic                  iSTART,
  input  logic [WIDTH-1:0]      iBIN,
  output logic                  oBUSY,
  output logic                  oDONE,
  output logic [4*DIGITS-1:0]   oBCD,
  output logic [DIGITS-1:0]     oBLANK
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);

  if (DIGITS < bcd_digits(WIDTH)) begin : g_bad_digits
    $error("bin2bcd_seq: DIGITS too small, 10**DIGITS must exceed 2**WIDTH-1");
  end

  state_t           r_state;
  logic [WIDTH-1:0] r_bin;
  logic [BW-1:0]    r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [BW-1:0]    r_bcd;
  logic [DIGITS-1:0] r_blank;

  logic [BW-1:0]     w_adj;
  logic [DIGITS-1:0] w_blank;
  logic              w_unused_adj_msb;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .i_digit (r_acc[4*g +: 4]),
      .o_digit (w_adj[4*g +: 4])
    );
  end

  // The adjusted MSB is shifted out; a legal DIGITS keeps it zero.
  assign w_unused_adj_msb = w_adj[BW-1];

`ifdef BIN2BCD_LZ_BLANK_EN
  localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(32'd1));

  // Digit i is blank when it and every digit above it are zero.
  function automatic logic [DIGITS-1:0] lz_mask(input logic [BW-1:0] acc);
    logic above;
    lz_mask = {DIGITS{1'b0}};
    above   = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      above      = above & (acc[4*i +: 4] == 4'd0);
      lz_mask[i] = above;
    end
    lz_mask[0] = 1'b0;
  endfunction

  assign w_blank = lz_mask(r_acc);
`else
  localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b0}};

  assign w_blank = {DIGITS{1'b0}};
`endif

  // Converter FSM: capture, shift-and-add-3 for WIDTH cycles, publish result.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state <= IDLE;
      r_bin   <= {WIDTH{1'b0}};
      r_acc   <= {BW{1'b0}};
      r_cnt   <= {CW{1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_bcd   <= {BW{1'b0}};
      r_blank <= BLANK_RST;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (iSTART) begin
            r_bin   <= iBIN;
            r_acc   <= {BW{1'b0}};
            r_cnt   <= CNT_LOAD;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        SHIFT: begin
          // {acc, bin} << 1 using the already-adjusted digits.
          r_acc <= {w_adj[BW-2:0], r_bin[WIDTH-1]};
          r_bin <= {r_bin[WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            r_state <= DONE;
          end else begin
            r_state <= SHIFT;
          end
        end
        DONE: begin
          // oBUSY stays high through the oDONE cycle and drops with it in IDLE.
          r_bcd   <= r_acc;
          r_blank <= w_blank;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign oBUSY  = r_busy;
  assign oDONE  = r_done;
  assign oBCD   = r_bcd;
  assign oBLANK = r_blank;

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

  localparam int WIDTH  = 16;
  localparam int DIGITS = 5;

`ifdef BIN2BCD_LZ_BLANK_EN
  localparam bit         LZ        = 1'b1;
  localparam logic [4:0] BLANK_RST = 5'b11110;
`else
  localparam bit         LZ        = 1'b0;
  localparam logic [4:0] BLANK_RST = 5'b00000;
`endif

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iSTART;
  logic [15:0] iBIN;
  logic        oBUSY;
  logic        oDONE;
  logic [19:0] oBCD;
  logic [4:0]  oBLANK;

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iSTART (iSTART),
    .iBIN   (iBIN),
    .oBUSY  (oBUSY),
    .oDONE  (oDONE),
    .oBCD   (oBCD),
    .oBLANK (oBLANK)
  );

  always #5 iCLK = ~iCLK;

  typedef struct packed {
    logic [19:0] bcd;
    logic [4:0]  blank;
  } exp_t;

  typedef struct {
    int          bin;
    logic [19:0] bcd;
    logic [4:0]  blank;
  } vec_t;

  exp_t q[$];
  vec_t bv[$];
  exp_t mon_e;

  int checks     = 0;
  int failures   = 0;
  int cyc        = 0;
  int prev_done  = -1;
  int done_cnt   = 0;
  bit burst      = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] ref_bcd(input int v);
    int t;
    t = v;
    ref_bcd = 20'h00000;
    for (int d = 0; d < 5; d++) begin
      ref_bcd[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
  endfunction

  function automatic logic [4:0] ref_blank(input logic [19:0] b);
    logic above;
    above = 1'b1;
    ref_blank = 5'b00000;
    for (int i = 4; i >= 1; i--) begin
      above = above & (b[4*i +: 4] == 4'd0);
      ref_blank[i] = above;
    end
  endfunction

  task automatic push(input logic [19:0] bcd, input logic [4:0] blank_on);
    exp_t e;
    e.bcd   = bcd;
    e.blank = LZ ? blank_on : 5'b00000;
    q.push_back(e);
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge iCLK);
    #1;
  endtask

  // Cycle counter.
  initial begin
    forever begin
      @(posedge iCLK);
      cyc++;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  initial begin
    forever begin
      @(negedge iCLK);
      if (!iRST && oDONE) begin
        done_cnt++;
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got oBCD=%0h expected no result", oBCD);
        end else begin
          mon_e = q.pop_front();
          chk("bcd", {12'h000, oBCD}, {12'h000, mon_e.bcd});
          chk("blank", {27'h0, oBLANK}, {27'h0, mon_e.blank});
        end
        if (burst && prev_done >= 0) begin
          chk("spacing", cyc - prev_done, 32'd18);
        end
        prev_done = cyc;
      end
    end
  end

  // Single conversion with latency and busy/done timing checks.
  task automatic run_one(input int bin, input logic [19:0] bcd, input logic [4:0] blank_on);
    int lat;
    bit busy_ok;
    logic busy_after;
    logic done_after;
    lat = -1;
    busy_ok = 1'b1;
    busy_after = 1'b1;
    done_after = 1'b1;
    wait_edges(1);
    push(bcd, blank_on);
    iSTART = 1'b1;
    iBIN   = 16'(bin);
    wait_edges(1);
    iSTART = 1'b0;
    iBIN   = ~16'(bin);
    for (int k = 0; k < 40; k++) begin
      @(negedge iCLK);
      if (lat < 0 && oDONE) begin
        lat = k;
        if (!oBUSY) busy_ok = 1'b0;
      end else if (lat >= 0 && k == lat + 1) begin
        busy_after = oBUSY;
        done_after = oDONE;
      end else if (lat < 0 && !oBUSY) begin
        busy_ok = 1'b0;
      end
    end
    chk("latency", lat, 32'd17);
    chk("busy_held", {31'h0, busy_ok}, 32'd1);
    chk("busy_fall", {31'h0, busy_after}, 32'd0);
    chk("done_pulse", {31'h0, done_after}, 32'd0);
  endtask

  // Back-to-back conversions with iSTART held high throughout.
  task automatic run_burst();
    int n;
    n = bv.size();
    wait_edges(1);
    burst = 1'b1;
    prev_done = -1;
    foreach (bv[i]) push(bv[i].bcd, bv[i].blank);
    iBIN   = 16'(bv[0].bin);
    iSTART = 1'b1;
    for (int i = 0; i < n; i++) begin
      wait_edges(1);
      if (i + 1 < n) begin
        iBIN = 16'(bv[i+1].bin);
        wait_edges(17);
      end else begin
        iSTART = 1'b0;
        iBIN   = 16'h0000;
      end
    end
    for (int k = 0; k < 60 && q.size() != 0; k++) @(negedge iCLK);
    chk("burst_drain", q.size(), 32'd0);
    wait_edges(2);
    burst = 1'b0;
    bv.delete();
  endtask

  initial begin
    int d0;
    vec_t v;
    iRST   = 1'b1;
    iSTART = 1'b0;
    iBIN   = 16'h0000;
    wait_edges(2);
    chk("rst_busy", {31'h0, oBUSY}, 32'd0);
    chk("rst_done", {31'h0, oDONE}, 32'd0);
    chk("rst_bcd", {12'h000, oBCD}, 32'd0);
    chk("rst_blank", {27'h0, oBLANK}, {27'h0, BLANK_RST});
    iRST = 1'b0;
    wait_edges(2);

    run_one(0,     20'h00000, 5'b11110);
    run_one(65535, 20'h65535, 5'b00000);
    run_one(1234,  20'h01234, 5'b10000);
    run_one(9,     20'h00009, 5'b11110);
    run_one(10,    20'h00010, 5'b11100);
    run_one(100,   20'h00100, 5'b11000);
    run_one(9999,  20'h09999, 5'b10000);
    run_one(10000, 20'h10000, 5'b00000);
    run_one(40960, 20'h40960, 5'b00000);

    // Starts during SHIFT and during the DONE state are ignored.
    wait_edges(1);
    d0 = done_cnt;
    push(20'h00999, 5'b11000);
    iSTART = 1'b1;
    iBIN   = 16'd999;
    wait_edges(1);
    iSTART = 1'b0;
    iBIN   = 16'd0;
    wait_edges(4);
    iSTART = 1'b1;
    iBIN   = 16'd42;
    wait_edges(1);
    iSTART = 1'b0;
    wait_edges(11);
    iSTART = 1'b1;
    iBIN   = 16'd42;
    wait_edges(1);
    iSTART = 1'b0;
    wait_edges(30);
    chk("one_done", done_cnt - d0, 32'd1);
    run_one(42, 20'h00042, 5'b11100);

    // Reset mid-conversion.
    wait_edges(1);
    iSTART = 1'b1;
    iBIN   = 16'd50000;
    wait_edges(1);
    iSTART = 1'b0;
    wait_edges(8);
    iRST = 1'b1;
    #1;
    chk("abort_busy", {31'h0, oBUSY}, 32'd0);
    chk("abort_done", {31'h0, oDONE}, 32'd0);
    chk("abort_bcd", {12'h000, oBCD}, 32'd0);
    chk("abort_blank", {27'h0, oBLANK}, {27'h0, BLANK_RST});
    d0 = done_cnt;
    wait_edges(2);
    iRST = 1'b0;
    wait_edges(30);
    chk("no_done_after_rst", done_cnt - d0, 32'd0);
    run_one(7, 20'h00007, 5'b11110);

    // Directed back-to-back burst.
    v.bin = 12345; v.bcd = 20'h12345; v.blank = 5'b00000; bv.push_back(v);
    v.bin = 54321; v.bcd = 20'h54321; v.blank = 5'b00000; bv.push_back(v);
    v.bin = 1;     v.bcd = 20'h00001; v.blank = 5'b11110; bv.push_back(v);
    v.bin = 60000; v.bcd = 20'h60000; v.blank = 5'b00000; bv.push_back(v);
    v.bin = 32768; v.bcd = 20'h32768; v.blank = 5'b00000; bv.push_back(v);
    v.bin = 8;     v.bcd = 20'h00008; v.blank = 5'b11110; bv.push_back(v);
    run_burst();

    // Boundary sweeps against the decimal reference.
    for (int x = 0; x < 60; x++) begin
      v.bin = x; v.bcd = ref_bcd(x); v.blank = ref_blank(v.bcd); bv.push_back(v);
    end
    for (int x = 65476; x < 65536; x++) begin
      v.bin = x; v.bcd = ref_bcd(x); v.blank = ref_blank(v.bcd); bv.push_back(v);
    end
    run_burst();

    wait_edges(5);
    chk("queue_empty", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
